chronos_runtime_cfg: RTL and testbench
======================================

CHRONOS_RUNTIME_CFG -- requirements
Module: chronos_runtime_cfg

Interface
REQ-001 Parameter N_TILES, default 1: number of tiles receiving quiesce handshake and per-tile masks.
REQ-002 Parameter N_CFG, default 8, range 1..32: number of runtime configuration registers.
REQ-003 Parameter CFG_WIDTH, default 32: width of each configuration register.
REQ-004 Parameter CFG_RESET, default all-zero, N_CFG*CFG_WIDTH bits: reset value of register i at slice i.
REQ-005 Parameter CFG_WMASK, default all-ones, N_CFG*CFG_WIDTH bits: writable bits; masked-off bits hold their reset value.
REQ-006 Parameter VERSION, default 10: constant returned by the version register.
REQ-007 Parameter DRAIN_TIMEOUT, default 4096: maximum cycles to wait for quiesce acknowledgement.
REQ-008 clk  in  1  sole clock.
REQ-009 rstn  in  1  asynchronous, active-low reset.
REQ-010 wr_valid / wr_ready  in / out  1  host write handshake.
REQ-011 wr_addr / wr_data  in  8 / 32  write word address / data.
REQ-012 rd_valid / rd_ready  in / out  1  host read request handshake.
REQ-013 rd_addr  in  8  read word address.
REQ-014 rdata_valid / rdata  out  1 / 32  read response.
REQ-015 quiesce_req  out  1  request all tiles to stop dequeuing tasks.
REQ-016 quiesce_ack  in  N_TILES  per-tile acknowledgement, level.
REQ-017 cfg_active  out  N_CFG*CFG_WIDTH  currently applied configuration.
REQ-018 cfg_epoch  out  8  count of successful commits, wraps modulo 256.

Function
REQ-019 Address map: 0x00 VERSION (RO); 0x01 STATUS (RO, bits [1:0] W1C); 0x02 COMMIT (WO); 0x10+i shadow register i; 0x90+i active register i (RO).
REQ-020 STATUS: bit0 timeout (sticky), bit1 bad_addr (sticky), bit2 busy (FSM not IDLE), bits[15:8] cfg_epoch.
REQ-021 A write completes in the cycle wr_valid && wr_ready; shadow register i takes (wr_data & mask) | (reset & ~mask), truncated to CFG_WIDTH.
REQ-022 Writes to RO, unmapped, or out-of-range (i >= N_CFG) addresses are dropped and set bad_addr.
REQ-023 wr_ready is 1 only in IDLE; the COMMIT write is accepted in IDLE and moves the FSM to DRAIN next cycle.
REQ-024 rd_ready is always 1; rdata_valid pulses exactly one cycle after the accepted read, with rdata sampled from the pre-write state.
REQ-025 Unmapped reads return 0 and set bad_addr.
REQ-026 FSM states: IDLE, DRAIN, APPLY, RELEASE.
REQ-027 DRAIN: quiesce_req=1; on &quiesce_ack go APPLY; when the timeout counter reaches DRAIN_TIMEOUT-1 set timeout and go RELEASE without applying.
REQ-028 APPLY, one cycle: cfg_active <= shadow, cfg_epoch++, go RELEASE.
REQ-029 RELEASE: quiesce_req=0; on |quiesce_ack==0 go IDLE; no timeout.
REQ-030 The timeout counter clears on every entry to DRAIN.
REQ-031 cfg_active changes only in APPLY; shadow writes never alter cfg_active directly.
REQ-032 A W1C write to STATUS and a simultaneous flag set in the same cycle: the set wins.

Reset
REQ-033 On rstn low, asynchronously: FSM=IDLE, shadow and cfg_active=CFG_RESET, cfg_epoch=0, flags=0, quiesce_req=0, rdata_valid=0, rdata=0, wr_ready=0 while in reset.
REQ-034 Reset mid-DRAIN or mid-APPLY aborts the commit; the first cycle after release is IDLE with reset values.

Verification
REQ-035 Read 0x00 after reset -> rdata=10, rdata_valid one cycle later; read 0x01 -> 0.
REQ-036 Write 0x10=0xDEADBEEF with mask 0x0000FFFF and reset 0 -> read 0x10=0x0000BEEF; 0x90 still 0.
REQ-037 COMMIT with N_TILES=4 and acks rising over 5 cycles -> quiesce_req high until all 4 acks are high, cfg_active updated one cycle later, cfg_epoch=1, wr_ready low throughout.
REQ-038 COMMIT with one ack stuck low, DRAIN_TIMEOUT=16 -> after 16 DRAIN cycles STATUS.timeout=1, cfg_active unchanged, epoch unchanged; W1C 0x1 clears the flag.
REQ-039 Write 0x05 and read 0xFF -> bad_addr=1, rdata=0, no register changes.
REQ-040 256 commits -> cfg_epoch wraps to 0; rstn pulsed during DRAIN -> quiesce_req=0 immediately, state restored to reset values.

Source files
------------

// File: rtl/chronos_runtime_cfg.sv
// chronos_runtime_cfg: shadow/active runtime config registers with quiesce-drain commit handshake.
module chronos_runtime_cfg #(
  parameter int N_TILES = 1,
  parameter int N_CFG = 8,
  parameter int CFG_WIDTH = 32,
  parameter logic [N_CFG*CFG_WIDTH-1:0] CFG_RESET = '0,
  parameter logic [N_CFG*CFG_WIDTH-1:0] CFG_WMASK = '1,
  parameter logic [31:0] VERSION = 32'd10,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [7:0]                   wr_addr,
  input  logic [31:0]                  wr_data,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [7:0]                   rd_addr,
  output logic                         rdata_valid,
  output logic [31:0]                  rdata,
  output logic                         quiesce_req,
  input  logic [N_TILES-1:0]           quiesce_ack,
  output logic [N_CFG*CFG_WIDTH-1:0]   cfg_active,
  output logic [7:0]                   cfg_epoch
);
  localparam int CW = CFG_WIDTH;
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(DRAIN_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY, RELEASE} state_t;
  state_t state;
  logic [TW-1:0] cnt;
  logic [N_CFG*CW-1:0] shadow;
  logic flag_tmo, flag_bad;
  logic [7:0] wr_idx, rd_idx, act_idx;
  logic wr_sh, rd_sh, rd_act, wr_fire, w1c, bad_w, bad_r, tmo_hit;
  logic [31:0] status, rd_word;
  assign wr_ready = rstn && state == IDLE;
  assign rd_ready = 1'b1;
  assign wr_fire = wr_valid && wr_ready;
  assign wr_idx = wr_addr - 8'h10;
  assign rd_idx = rd_addr - 8'h10;
  assign act_idx = rd_addr - 8'h90;
  assign wr_sh = wr_addr >= 8'h10 && wr_idx < 8'(N_CFG);
  assign rd_sh = rd_addr >= 8'h10 && rd_idx < 8'(N_CFG);
  assign rd_act = rd_addr >= 8'h90 && act_idx < 8'(N_CFG);
  assign w1c = wr_fire && wr_addr == 8'h01;
  assign bad_w = wr_fire && !(wr_addr == 8'h01 || wr_addr == 8'h02 || wr_sh);
  assign bad_r = rd_valid && !(rd_addr <= 8'h02 || rd_sh || rd_act);
  assign tmo_hit = state == DRAIN && !(&quiesce_ack) && cnt == LAST;
  assign status = {16'h0, cfg_epoch, 5'h0, state != IDLE, flag_bad, flag_tmo};
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_CFG; i++) begin
      if (rd_sh && rd_idx == 8'(i)) rd_word = 32'(shadow[i*CW +: CW]);
      if (rd_act && act_idx == 8'(i)) rd_word = 32'(cfg_active[i*CW +: CW]);
    end
    if (rd_addr == 8'h00) rd_word = VERSION;
    if (rd_addr == 8'h01) rd_word = status;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      shadow <= CFG_RESET;
      cfg_active <= CFG_RESET;
      cfg_epoch <= '0;
      flag_tmo <= 1'b0;
      flag_bad <= 1'b0;
      quiesce_req <= 1'b0;
      rdata_valid <= 1'b0;
      rdata <= '0;
    end else begin
      rdata_valid <= rd_valid;
      rdata <= rd_valid ? rd_word : '0;
      // a new flag event in the same cycle as its W1C clear keeps the flag set
      flag_bad <= (flag_bad && !(w1c && wr_data[1])) || bad_w || bad_r;
      flag_tmo <= (flag_tmo && !(w1c && wr_data[0])) || tmo_hit;
      for (int i = 0; i < N_CFG; i++)
        if (wr_fire && wr_sh && wr_idx == 8'(i))
          shadow[i*CW +: CW] <= (CW'(wr_data) & CFG_WMASK[i*CW +: CW]) | (CFG_RESET[i*CW +: CW] & ~CFG_WMASK[i*CW +: CW]);
      case (state)
        IDLE: if (wr_fire && wr_addr == 8'h02) begin
          state <= DRAIN;
          quiesce_req <= 1'b1;
          cnt <= '0;
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (&quiesce_ack) state <= APPLY;
          else if (cnt == LAST) begin
            state <= RELEASE;
            quiesce_req <= 1'b0;
          end
        end
        // tiles stay quiesced while the new configuration lands
        APPLY: begin
          cfg_active <= shadow;
          cfg_epoch <= cfg_epoch + 8'd1;
          state <= RELEASE;
          quiesce_req <= 1'b0;
        end
        default: if (!(|quiesce_ack)) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chronos_runtime_cfg.sv
// tb_chronos_runtime_cfg: scoreboard bench for the runtime config block.
module tb_chronos_runtime_cfg;
  localparam int NT = 4;
  localparam int NC = 4;
  localparam int CW = 32;
  logic clk = 0;
  logic rstn = 0;
  logic wr_valid = 0, rd_valid = 0;
  logic [7:0] wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic wr_ready, rd_ready, rdata_valid, quiesce_req;
  logic [31:0] rdata;
  logic [NC*CW-1:0] cfg_active;
  logic [7:0] cfg_epoch;
  logic [NT-1:0] ack_man = 0, q_d = 0, ack;
  logic auto_ack = 0;
  int cyc = 0;
  int total = 0, bad = 0;
  typedef struct {logic [7:0] a; logic [31:0] d; int c;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) q_d <= {NT{quiesce_req}};
  assign ack = auto_ack ? q_d : ack_man;
  chronos_runtime_cfg #(
    .N_TILES(NT), .N_CFG(NC), .CFG_WIDTH(CW),
    .CFG_RESET({32'h0, 32'h0, 32'h0000A5A5, 32'h0}),
    .CFG_WMASK({32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF0000, 32'h0000FFFF}),
    .VERSION(32'd10), .DRAIN_TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .quiesce_req(quiesce_req), .quiesce_ack(ack),
    .cfg_active(cfg_active), .cfg_epoch(cfg_epoch)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rdata_valid) begin
      if (sb.size() == 0) chk("rd_unexp", 32'(rdata_valid), 0);
      else begin
        e = sb.pop_front();
        chk($sformatf("rd_%02h", e.a), rdata, e.d);
        chk("rd_lat", cyc, e.c);
      end
    end
  end
  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    @(negedge clk);
    rd_valid = 1;
    rd_addr = a;
    sb.push_back('{a, e, cyc + 1});
    @(negedge clk);
    rd_valid = 0;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) chk("wr_ready_wait", 32'(wr_ready), 1);
    wr_valid = 1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_valid = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    logic [3:0] pat [5];
    int n;
    pat = '{4'h1, 4'h3, 4'h7, 4'h7, 4'hF};
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_q", 32'(quiesce_req), 0);
    chk("rst_rvalid", 32'(rdata_valid), 0);
    chk("rst_epoch", 32'(cfg_epoch), 0);
    chk("rst_act1", cfg_active[63:32], 32'h0000A5A5);
    rstn = 1;
    @(negedge clk);
    chk("idle_wr_ready", 32'(wr_ready), 1);
    rd(8'h00, 32'd10);
    rd(8'h01, 32'h0);
    rd(8'h91, 32'h0000A5A5);
    wr(8'h10, 32'hDEADBEEF);
    wr(8'h11, 32'h12345678);
    rd(8'h10, 32'h0000BEEF);
    rd(8'h11, 32'h1234A5A5);
    rd(8'h90, 32'h0);
    chk("act0_pre", cfg_active[31:0], 32'h0);
    // commit with acks rising over five cycles
    wr(8'h02, 32'h0);
    chk("drain_q", 32'(quiesce_req), 1);
    chk("drain_wr_ready", 32'(wr_ready), 0);
    for (int k = 0; k < 5; k++) begin
      ack_man = pat[k];
      @(negedge clk);
      if (k < 4) begin
        chk($sformatf("drain_q_%0d", k), 32'(quiesce_req), 1);
        chk($sformatf("drain_rdy_%0d", k), 32'(wr_ready), 0);
        chk($sformatf("drain_act_%0d", k), cfg_active[31:0], 32'h0);
      end
    end
    n = 0;
    while (cfg_epoch != 8'd1 && n < 8) begin
      chk("apply_wr_ready", 32'(wr_ready), 0);
      @(negedge clk);
      n++;
    end
    chk("epoch1", 32'(cfg_epoch), 1);
    chk("act0_commit", cfg_active[31:0], 32'h0000BEEF);
    chk("act1_commit", cfg_active[63:32], 32'h1234A5A5);
    chk("release_q", 32'(quiesce_req), 0);
    chk("release_rdy", 32'(wr_ready), 0);
    ack_man = 0;
    @(negedge clk);
    chk("back_idle", 32'(wr_ready), 1);
    rd(8'h90, 32'h0000BEEF);
    rd(8'h01, 32'h00000100);
    // commit that times out on a stuck tile
    wr(8'h10, 32'h0000CAFE);
    ack_man = 4'h7;
    wr(8'h02, 32'h0);
    n = 0;
    while (quiesce_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_epoch", 32'(cfg_epoch), 1);
    chk("tmo_act0", cfg_active[31:0], 32'h0000BEEF);
    ack_man = 0;
    @(negedge clk);
    rd(8'h01, 32'h00000101);
    rd(8'h90, 32'h0000BEEF);
    wr(8'h01, 32'h1);
    rd(8'h01, 32'h00000100);
    // bad addresses
    wr(8'h05, 32'hFFFF);
    rd(8'h01, 32'h00000102);
    wr(8'h01, 32'h2);
    rd(8'hFF, 32'h0);
    rd(8'h01, 32'h00000102);
    wr(8'h01, 32'h2);
    wr(8'h14, 32'h1);
    wr(8'h90, 32'h1);
    rd(8'h94, 32'h0);
    rd(8'h10, 32'h0000CAFE);
    rd(8'h13, 32'h0);
    rd(8'h90, 32'h0000BEEF);
    wr(8'h01, 32'h2);
    rd(8'h01, 32'h00000100);
    // W1C and a bad read in the same cycle: flag stays set
    @(negedge clk);
    wr_valid = 1;
    wr_addr = 8'h01;
    wr_data = 32'h2;
    rd_valid = 1;
    rd_addr = 8'hFF;
    sb.push_back('{8'hFF, 32'h0, cyc + 1});
    @(negedge clk);
    wr_valid = 0;
    rd_valid = 0;
    rd(8'h01, 32'h00000102);
    wr(8'h01, 32'h3);
    rd(8'h01, 32'h00000100);
    // 255 more successful commits wrap the epoch
    auto_ack = 1;
    for (int i = 0; i < 255; i++) wr(8'h02, 32'h0);
    n = 0;
    while (!wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_idle", 32'(wr_ready), 1);
    chk("wrap_epoch", 32'(cfg_epoch), 0);
    rd(8'h01, 32'h0);
    auto_ack = 0;
    ack_man = 0;
    // reset in the middle of a drain
    wr(8'h10, 32'h1111);
    wr(8'h02, 32'h0);
    chk("pre_rst_q", 32'(quiesce_req), 1);
    rstn = 0;
    #1;
    chk("arst_q", 32'(quiesce_req), 0);
    chk("arst_rdy", 32'(wr_ready), 0);
    chk("arst_act0", cfg_active[31:0], 32'h0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(wr_ready), 1);
    chk("post_rst_q", 32'(quiesce_req), 0);
    chk("post_rst_epoch", 32'(cfg_epoch), 0);
    chk("post_rst_act1", cfg_active[63:32], 32'h0000A5A5);
    rd(8'h10, 32'h0);
    rd(8'h11, 32'h0000A5A5);
    rd(8'h01, 32'h0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
